mem_responder: RTL and testbench

//   Memory-side responder for the CPU memory port (mem_mar_we, mem_ram_we, bus, mem_out).

---
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side partner of the CPU memory port.
//   Holds the MAR and a 2**ADDR_W byte RAM. After reset, a boot loader streams a program
//   into RAM from address 0 over a valid/ready byte interface. The CPU is held in reset
//   until loading completes.
// Ports:
//   CLK, rst              clock, synchronous active-high reset
//   bus                   CPU bus: [ADDR_W-1:0] = address, [7:0] = write data
//   mem_mar_we/mem_ram_we CPU strobes: load MAR / write RAM[MAR]
//   mem_out               RAM[MAR] (combinational), zero while loading
//   load_valid/_data/_last, load_ready   loader byte stream
//   reload                pulse in RUN: restart loading
//   cpu_rst               CPU reset, high while loading
//   load_ptr              next loader write address
module mem_responder #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [15:0]       bus,
   input  logic              mem_mar_we,
   input  logic              mem_ram_we,
   output logic [7:0]        mem_out,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              reload,
   output logic              cpu_rst,
   output logic [ADDR_W-1:0] load_ptr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PtrMax = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StLoad, StRun} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [7:0]        ram_q [DEPTH];

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [7:0]        ram_wdata;

   // Bus bits above the data byte only matter as address bits for wide ADDR_W.
   logic unused_bus;
   assign unused_bus = ^bus[15:8];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      mar_d     = mar_q;
      ram_we    = 1'b0;
      ram_waddr = ptr_q;
      ram_wdata = load_data;
      unique case (state_q)
         StLoad: begin
            // load_ready is high throughout LOAD, so valid alone means accept.
            if (load_valid) begin
               ram_we = 1'b1;
               ptr_d  = ptr_q + 1'b1;  // wraps to 0 after the last address
               if (load_last || ptr_q == PtrMax) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            // The write always uses the MAR value from before this edge.
            if (mem_ram_we) begin
               ram_we    = 1'b1;
               ram_waddr = mar_q;
               ram_wdata = bus[7:0];
            end
            if (reload) begin
               state_d = StLoad;
               ptr_d   = '0;
               mar_d   = '0;
            end else if (mem_mar_we) begin
               mar_d = bus[ADDR_W-1:0];
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= StLoad;
         ptr_q   <= '0;
         mar_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mar_q   <= mar_d;
      end
   end

   // RAM is deliberately not cleared by reset; a partial load stays visible.
   always_ff @(posedge CLK) begin
      if (!rst && ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
   end

   always_comb begin
      load_ready = (state_q == StLoad);
      cpu_rst    = (state_q == StLoad);
      load_ptr   = ptr_q;
      mem_out    = (state_q == StRun) ? ram_q[mar_q] : 8'h00;
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        CLK = 1'b0;
   logic        rst;
   logic [15:0] bus;
   logic        mem_mar_we, mem_ram_we;
   logic [7:0]  mem_out;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        reload;
   logic        cpu_rst;
   logic [7:0]  load_ptr;

   int checks = 0;
   int errors = 0;

   mem_responder #(.ADDR_W(8)) dut (
      .CLK        (CLK),
      .rst        (rst),
      .bus        (bus),
      .mem_mar_we (mem_mar_we),
      .mem_ram_we (mem_ram_we),
      .mem_out    (mem_out),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .reload     (reload),
      .cpu_rst    (cpu_rst),
      .load_ptr   (load_ptr)
   );

   always #5 CLK = ~CLK;

   // Behavioural model: a running flag, a pointer, a MAR and a byte array.
   bit model_valid = 0;
   bit m_running;
   int m_ptr, m_mar;
   int m_ram [256];
   bit m_known [256];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge CLK) begin
      if (rst) begin
         model_valid = 1;
         m_running   = 0;
         m_ptr       = 0;
         m_mar       = 0;
      end else if (model_valid) begin
         if (!m_running) begin
            if (load_valid) begin
               m_ram[m_ptr]   = int'(load_data);
               m_known[m_ptr] = 1;
               if (load_last || m_ptr == 255) m_running = 1;
               m_ptr = (m_ptr + 1) % 256;
            end
         end else begin
            if (mem_ram_we) begin
               m_ram[m_mar]   = int'(bus) & 'hFF;
               m_known[m_mar] = 1;
            end
            if (reload) begin
               m_running = 0;
               m_ptr     = 0;
               m_mar     = 0;
            end else if (mem_mar_we) begin
               m_mar = int'(bus) & 'hFF;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (model_valid) begin
         check("cpu_rst", int'(cpu_rst), m_running ? 0 : 1);
         check("load_ready", int'(load_ready), m_running ? 0 : 1);
         check("load_ptr", int'(load_ptr), m_ptr);
         if (!m_running) check("mem_out_load", int'(mem_out), 0);
         else if (m_known[m_mar]) check("mem_out_run", int'(mem_out), m_ram[m_mar]);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_data  = 8'($urandom);
      load_last  = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic cpu_op(input logic mw, input logic rw, input logic [15:0] b);
      mem_mar_we = mw;
      mem_ram_we = rw;
      bus        = b;
      tick();
      mem_mar_we = 1'b0;
      mem_ram_we = 1'b0;
   endtask

   int bytes [256];

   initial begin
      rst = 1'b1; bus = '0; mem_mar_we = 0; mem_ram_we = 0;
      load_valid = 0; load_data = '0; load_last = 0; reload = 0;

      // 1: reset state and MAR strobes ignored while loading
      tick(); tick();
      check("rst_cpu_rst", int'(cpu_rst), 1);
      check("rst_load_ready", int'(load_ready), 1);
      check("rst_mem_out", int'(mem_out), 0);
      check("rst_load_ptr", int'(load_ptr), 0);
      rst = 1'b0;
      cpu_op(1'b1, 1'b1, 16'h0055);
      check("load_ptr_after_ignored_strobe", int'(load_ptr), 0);

      // 2: short program with gaps
      send_byte(8'h3E, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h76, 1'b1);
      check("prog_load_ptr", int'(load_ptr), 3);
      check("prog_cpu_rst", int'(cpu_rst), 0);
      check("prog_load_ready", int'(load_ready), 0);
      check("prog_mar_held_zero", int'(mem_out), 'h3E);
      cpu_op(1'b1, 1'b0, 16'h0001);
      check("read_addr1", int'(mem_out), 'h05);

      // 3: write then read, upper bus bits dropped
      cpu_op(1'b1, 1'b0, 16'h0010);
      cpu_op(1'b0, 1'b1, 16'h00AA);
      check("raw_same_addr", int'(mem_out), 'hAA);
      cpu_op(1'b1, 1'b0, 16'h0000);
      cpu_op(1'b1, 1'b0, 16'hFF10);
      check("mar_upper_dropped", int'(mem_out), 'hAA);

      // 4: simultaneous strobes write old MAR, then move MAR
      cpu_op(1'b1, 1'b0, 16'h0020);
      cpu_op(1'b0, 1'b1, 16'h0077);
      cpu_op(1'b1, 1'b0, 16'h0010);
      cpu_op(1'b1, 1'b1, 16'h0020);
      check("both_new_mar_untouched", int'(mem_out), 'h77);
      cpu_op(1'b1, 1'b0, 16'h0010);
      check("both_old_mar_written", int'(mem_out), 'h20);

      // Random RUN traffic, loader inputs toggling and ignored
      for (int i = 0; i < 200; i++) begin
         load_valid = 1'($urandom);
         load_data  = 8'($urandom);
         load_last  = 1'($urandom);
         cpu_op(1'($urandom), 1'($urandom), 16'($urandom));
      end
      load_valid = 1'b0;

      // 6a: reload
      reload = 1'b1; tick(); reload = 1'b0;
      check("reload_cpu_rst", int'(cpu_rst), 1);
      check("reload_load_ptr", int'(load_ptr), 0);

      // 5: full 256-byte load with no last marker
      for (int a = 0; a < 256; a++) begin
         bytes[a] = int'($urandom_range(0, 255));
         send_byte(8'(bytes[a]), 1'b0);
      end
      check("full_load_ptr_wrap", int'(load_ptr), 0);
      check("full_cpu_rst", int'(cpu_rst), 0);
      for (int a = 0; a < 256; a++) begin
         cpu_op(1'b1, 1'b0, {8'($urandom), 8'(a)});
         check("readback", int'(mem_out), bytes[a]);
      end

      // 6b: rst part-way through a load
      reload = 1'b1; tick(); reload = 1'b0;
      send_byte(8'hA1, 1'b0);
      send_byte(8'hB2, 1'b0);
      check("partial_load_ptr", int'(load_ptr), 2);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_load_ptr", int'(load_ptr), 0);
      check("rst_mid_load_ready", int'(load_ready), 1);
      send_byte(8'hC3, 1'b1);
      cpu_op(1'b1, 1'b0, 16'h0001);
      check("retained_addr1", int'(mem_out), 'hB2);
      cpu_op(1'b1, 1'b0, 16'h0000);
      check("reloaded_addr0", int'(mem_out), 'hC3);

      for (int i = 0; i < 100; i++) begin
         reload = ($urandom_range(0, 19) == 0);
         cpu_op(1'($urandom), 1'($urandom), 16'($urandom));
         reload = 1'b0;
         if (cpu_rst) send_byte(8'($urandom), 1'b1);
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
